regfile_wb: RTL
===============

Name: regfile_wb

Overview:
- Architectural register file that receives the writeback stream at the end of the MEM/WB stage.
- The MEM/WB stage presents final write enable, destination and data; this block commits them on the clock edge and serves two combinational read ports to decode.
- A per-register pending-write scoreboard is included. Decode marks a destination busy at issue, and the WB write clears it. Decode uses the busy outputs for stall decisions.

Parameters:
- DW, 32, data width of each register
- AW, 5, register index width
- NREG, 32, number of registers (2**AW); register 0 hardwired to zero

Ports:
- clk  input  1  clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- wb_reg_write_final  input  1  writeback enable from MEM/WB
- wb_writereg  input  AW  writeback destination index
- wb_wdata  input  DW  writeback data
- id_rs  input  AW  read port A index
- id_rt  input  AW  read port B index
- id_rs_data  output  DW  read port A data (combinational)
- id_rt_data  output  DW  read port B data (combinational)
- id_issue  input  1  decode issues an instruction that will write id_issue_rd
- id_issue_rd  input  AW  destination of issued instruction
- flush  input  1  pipeline flush; clears all pending marks
- id_rs_busy  output  1  register id_rs has a pending write
- id_rt_busy  output  1  register id_rt has a pending write
- busy_vec  output  NREG  full scoreboard, bit i = register i pending

Behaviour:
- Reset (reset_n=0, async): all registers = 0 and all busy bits = 0.
  - While in reset: id_rs_data = id_rt_data = 0, id_rs_busy = id_rt_busy = 0, busy_vec = 0.
- Write:
  - On posedge clk, if wb_reg_write_final=1 and wb_writereg!=0, then reg[wb_writereg] <= wb_wdata.
  - Writes to index 0 are discarded.
  - Write latency is 1 cycle: the value is visible to array reads in the next cycle.
- Read:
  - id_rs_data = (id_rs==0) ? 0 : reg[id_rs]; same rule for id_rt.
  - Reads are purely combinational, with no read latency.
  - Same-cycle bypass is governed by WB_BYPASS_EN.
- Scoreboard, next-state per bit i (i != 0):
  - flush=1: busy[i] <= 0. Issue is ignored in the same cycle; a WB write in the same cycle still updates the array.
  - Otherwise, set = id_issue && id_issue_rd==i, and clr = wb_reg_write_final && wb_writereg==i.
  - set=1 gives busy <= 1. Set wins over a simultaneous clear to the same register (new producer).
  - clr=1 and set=0 gives busy <= 0.
  - Otherwise busy[i] holds.
  - busy[0] is constant 0; issue to rd=0 is ignored.
  - Multiple outstanding issues to the same register are not counted; a single bit tracks only the latest producer. Only one WB is allowed in flight per register; decode guarantees this by stalling on busy.
- Busy outputs:
  - id_rs_busy = busy[id_rs], subject to the WB_BYPASS_EN qualification below; same rule for id_rt.
  - busy_vec reflects the registered bits only.
- Read indices have no handshake and may change every cycle.
- Reset asserted mid-operation discards all pending writes and busy state immediately.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined:
  - Write-through. If wb_reg_write_final=1, wb_writereg!=0 and wb_writereg==id_rs, then id_rs_data = wb_wdata in the same cycle; same rule for id_rt.
  - id_rs_busy/id_rt_busy are masked to 0 when the same-cycle WB write targets that register, so a consumer in decode needs no stall for that register.
- Undefined:
  - Reads return the pre-write array value during the write cycle.
  - Busy outputs are the raw registered bits; decode stalls one extra cycle.

Test Plan:
1. Reset then read all 32 indices -> every id_rs_data/id_rt_data = 0, busy_vec = 0.
2. WB write reg 5 = 0xDEADBEEF at cycle N, id_rs=5:
   - With bypass: cycle N reads 0xDEADBEEF.
   - Without bypass: cycle N reads the old value 0; cycle N+1 reads 0xDEADBEEF in both builds.
3. WB write reg 0 = 0x12345678 -> id_rs=0 reads 0 in all following cycles; issue rd=0 leaves busy_vec[0]=0.
4. Scoreboard:
   - Issue rd=8 at cycle N -> busy_vec[8]=1 from N+1.
   - WB write reg 8 at cycle N+3 -> busy_vec[8]=0 from N+4.
   - id_rs=8 busy at N+3 is 0 with bypass and 1 without.
5. Same cycle: issue rd=9 and WB write reg 9 = 0xA5A5A5A5 -> reg9 = 0xA5A5A5A5 and busy_vec[9]=1 next cycle.
6. Flush and reset:
   - Issue rd=3,4,7, then flush together with issue rd=10 -> busy_vec = 0 next cycle.
   - Assert reset_n=0 mid-run -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_wb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb
// Function : Architectural register file fed by the MEM/WB writeback stream.
//            It has two combinational read ports and a per-register
//            pending-write scoreboard.
// Options  : REGFILE_WB_BYPASS_EN enables same-cycle write-through on reads
//            and masks busy for the register being written back.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            wb_reg_write_final,
    input  logic [AW-1:0]   wb_writereg,
    input  logic [DW-1:0]   wb_wdata,
    input  logic [AW-1:0]   id_rs,
    input  logic [AW-1:0]   id_rt,
    output logic [DW-1:0]   id_rs_data,
    output logic [DW-1:0]   id_rt_data,
    input  logic            id_issue,
    input  logic [AW-1:0]   id_issue_rd,
    input  logic            flush,
    output logic            id_rs_busy,
    output logic            id_rt_busy,
    output logic [NREG-1:0] busy_vec
);

    logic [DW-1:0]   regs_q [NREG];
    logic [DW-1:0]   regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    logic            wb_en;
    logic [DW-1:0]   rs_arr;
    logic [DW-1:0]   rt_arr;
    logic            rs_hit;
    logic            rt_hit;

    assign wb_en = wb_reg_write_final && (wb_writereg != '0);

    always_comb begin
        regs_d = regs_q;
        if (wb_en) begin
            regs_d[wb_writereg] = wb_wdata;
        end
        regs_d[0] = '0;
    end

    // Set beats clear: a same-cycle issue is a newer producer than the WB.
    always_comb begin
        busy_d = busy_q;
        for (int i = 1; i < NREG; i++) begin
            if (flush) begin
                busy_d[i] = 1'b0;
            end else if (id_issue && (id_issue_rd == AW'(i))) begin
                busy_d[i] = 1'b1;
            end else if (wb_reg_write_final && (wb_writereg == AW'(i))) begin
                busy_d[i] = 1'b0;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign rs_arr = (id_rs == '0) ? '0 : regs_q[id_rs];
    assign rt_arr = (id_rt == '0) ? '0 : regs_q[id_rt];

    // Qualified by reset_n so a write presented during reset cannot leak out.
    assign rs_hit = reset_n && wb_en && (wb_writereg == id_rs);
    assign rt_hit = reset_n && wb_en && (wb_writereg == id_rt);

`ifdef REGFILE_WB_BYPASS_EN
    assign id_rs_data = rs_hit ? wb_wdata : rs_arr;
    assign id_rt_data = rt_hit ? wb_wdata : rt_arr;
    assign id_rs_busy = busy_q[id_rs] && !rs_hit;
    assign id_rt_busy = busy_q[id_rt] && !rt_hit;
`else
    logic unused_hits;
    assign unused_hits = rs_hit ^ rt_hit;
    assign id_rs_data  = rs_arr;
    assign id_rt_data  = rt_arr;
    assign id_rs_busy  = busy_q[id_rs];
    assign id_rt_busy  = busy_q[id_rt];
`endif

    assign busy_vec = busy_q;

endmodule
`default_nettype wire
